// File: rtl/load_store_unit_if.sv
// Load/store unit bus: datapath request/result signals plus the data-memory port.
// The misaligned flag exists only when MISALIGN_TRAP_EN is defined.
// master: datapath + memory side; slave: the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned LANES = WIDTH / 8;

    logic             start;
    logic             is_store;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] store_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] mem_address;
    logic             mem_read;
    logic             mem_write;
    logic [LANES-1:0] mem_byte_enable;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_resp;
`ifdef MISALIGN_TRAP_EN
    logic             misaligned;
`endif

    modport master (
`ifdef MISALIGN_TRAP_EN
        input  misaligned,
`endif
        output start, is_store, funct3, addr, store_data, mem_rdata, mem_resp,
        input  busy, done, load_data, mem_address, mem_read, mem_write,
               mem_byte_enable, mem_wdata
    );

    modport slave (
`ifdef MISALIGN_TRAP_EN
        output misaligned,
`endif
        input  start, is_store, funct3, addr, store_data, mem_rdata, mem_resp,
        output busy, done, load_data, mem_address, mem_read, mem_write,
               mem_byte_enable, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multicycle RV32I load/store sequencer: IDLE -> REQ -> DONE -> IDLE.
// Store data is lane-shifted with byte enables; load data is shifted down and extended.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned h/w accesses skip memory and
// complete with the misaligned flag instead of issuing a truncated request).
module load_store_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    localparam int unsigned LANES = WIDTH / 8;
    localparam int unsigned OFF_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               is_store_q, is_store_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [LANES-1:0]   be_q, be_d;
    logic [WIDTH-1:0]   address_q, address_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   load_data_q, load_data_d;
`ifdef MISALIGN_TRAP_EN
    logic               misaligned_q, misaligned_d;
    logic               misaligned_in;
`endif

    logic [OFF_W-1:0]   off_in;
    logic [LANES-1:0]   be_in;
    logic [WIDTH-1:0]   wdata_in;
    logic [WIDTH-1:0]   rdata_shifted;
    logic [WIDTH-1:0]   load_ext;

    assign off_in   = bus.addr[OFF_W-1:0];
    assign wdata_in = bus.store_data << {off_in, 3'b000};

    // Store lane enables from the incoming width code, truncated at the word edge
    always_comb begin
        be_in = '0;
        case (bus.funct3[1:0])
            2'b00:   be_in = LANES'(4'b0001 << off_in);
            2'b01:   be_in = LANES'(4'b0011 << off_in);
            default: be_in = LANES'(4'b1111);
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Halfwords need an even address, words a word-aligned one
    always_comb begin
        misaligned_in = 1'b0;
        case (bus.funct3[1:0])
            2'b01:        misaligned_in = bus.addr[0];
            2'b10, 2'b11: misaligned_in = |bus.addr[1:0];
            default:      misaligned_in = 1'b0;
        endcase
    end
`endif

    assign rdata_shifted = bus.mem_rdata >> {off_q, 3'b000};

    // Extend the shifted read data according to the latched width code
    always_comb begin
        load_ext = rdata_shifted;
        case (funct3_q)
            3'b000:  load_ext = {{(WIDTH-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_ext = {{(WIDTH-8){1'b0}}, rdata_shifted[7:0]};
            3'b001:  load_ext = {{(WIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_ext = {{(WIDTH-16){1'b0}}, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // Next-state and next-output logic; every output leaves a flop
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        is_store_d  = is_store_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        read_d      = read_q;
        write_d     = write_q;
        be_d        = be_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
`ifdef MISALIGN_TRAP_EN
        misaligned_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    off_d      = off_in;
                    funct3_d   = bus.funct3;
                    is_store_d = bus.is_store;
                    busy_d     = 1'b1;
                    address_d  = {bus.addr[WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_d    = wdata_in;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned_in) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        read_d  = !bus.is_store;
                        write_d = bus.is_store;
                        be_d    = bus.is_store ? be_in : '0;
                    end
`else
                    state_d = REQ;
                    read_d  = !bus.is_store;
                    write_d = bus.is_store;
                    be_d    = bus.is_store ? be_in : '0;
`endif
                end
            end
            REQ: begin
                if (bus.mem_resp) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    be_d    = '0;
                    if (!is_store_q) begin
                        load_data_d = load_ext;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                read_d  = 1'b0;
                write_d = 1'b0;
                be_d    = '0;
            end
        endcase
    end

    // State and output registers; async reset clears any outstanding request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            off_q       <= '0;
            funct3_q    <= '0;
            is_store_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            be_q        <= '0;
            address_q   <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
`ifdef MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            is_store_q  <= is_store_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            read_q      <= read_d;
            write_q     <= write_d;
            be_q        <= be_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
`ifdef MISALIGN_TRAP_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.load_data       = load_data_q;
    assign bus.mem_address     = address_q;
    assign bus.mem_read        = read_q;
    assign bus.mem_write       = write_q;
    assign bus.mem_byte_enable = be_q;
    assign bus.mem_wdata       = wdata_q;
`ifdef MISALIGN_TRAP_EN
    assign bus.misaligned      = misaligned_q;
`endif
endmodule
